// File: rtl/capture_rr_arbiter_if.sv
// Handshake bundle for capture_rr_arbiter: two requester channels, the
// downstream capture slot and the debug grant counters.
interface capture_rr_arbiter_if #(
    parameter int DW = 3,
    parameter int OW = 4,
    parameter int CW = 4
) ();
    logic          req1_valid;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          req2_valid;
    logic [DW-1:0] req2_data;
    logic          req2_ready;
    logic          cap_valid;
    logic [OW-1:0] cap_data;
    logic          cap_src;
    logic          cap_ready;
    logic          cnt_clr;
    logic [CW-1:0] grant_cnt1;
    logic [CW-1:0] grant_cnt2;

    modport master (
        output req1_valid, req1_data, req2_valid, req2_data, cap_ready, cnt_clr,
        input  req1_ready, req2_ready, cap_valid, cap_data, cap_src,
               grant_cnt1, grant_cnt2
    );

    modport slave (
        input  req1_valid, req1_data, req2_valid, req2_data, cap_ready, cnt_clr,
        output req1_ready, req2_ready, cap_valid, cap_data, cap_src,
               grant_cnt1, grant_cnt2
    );
endinterface

// File: rtl/capture_rr_arbiter.sv
// Round-robin arbiter that loads one registered capture slot from two narrow
// requesters and keeps saturating per-requester grant counters.
module capture_rr_arbiter #(
    parameter int DW = 3,
    parameter int OW = 4,
    parameter int CW = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    capture_rr_arbiter_if.slave bus
);
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic [OW-1:0] cap_data_q, cap_data_d;
    logic          cap_src_q, cap_src_d;
    logic [CW-1:0] cnt1_q, cnt1_d;
    logic [CW-1:0] cnt2_q, cnt2_d;
    logic          slot_free_s;
    logic          gnt1_s;
    logic          gnt2_s;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (v == {CW{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CW-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    function automatic logic [OW-1:0] zext(input logic [DW-1:0] d);
        logic [OW-1:0] r;
        r          = {OW{1'b0}};
        r[DW-1:0]  = d;
        return r;
    endfunction

    // Grant selection; ptr_q holds the last winner (0 = req1), so a tie goes to the other one.
    always_comb begin
        slot_free_s = (state_q == ST_EMPTY) | bus.cap_ready;
        gnt1_s      = 1'b0;
        gnt2_s      = 1'b0;
        if (slot_free_s) begin
            if (bus.req1_valid && bus.req2_valid) begin
                if (ptr_q) begin
                    gnt1_s = 1'b1;
                end else begin
                    gnt2_s = 1'b1;
                end
            end else if (bus.req1_valid) begin
                gnt1_s = 1'b1;
            end else if (bus.req2_valid) begin
                gnt2_s = 1'b1;
            end else begin
                gnt1_s = 1'b0;
                gnt2_s = 1'b0;
            end
        end else begin
            gnt1_s = 1'b0;
            gnt2_s = 1'b0;
        end
    end

    // Slot FSM: a grant always (re)loads the slot, otherwise a consumed slot empties.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cap_data_d = cap_data_q;
        cap_src_d  = cap_src_q;
        case (state_q)
            ST_EMPTY, ST_FULL: begin
                if (gnt1_s) begin
                    state_d    = ST_FULL;
                    ptr_d      = 1'b0;
                    cap_data_d = zext(bus.req1_data);
                    cap_src_d  = 1'b0;
                end else if (gnt2_s) begin
                    state_d    = ST_FULL;
                    ptr_d      = 1'b1;
                    cap_data_d = zext(bus.req2_data);
                    cap_src_d  = 1'b1;
                end else if ((state_q == ST_FULL) && bus.cap_ready) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Grant counters; a clear wins over a coincident grant.
    always_comb begin
        cnt1_d = cnt1_q;
        cnt2_d = cnt2_q;
        if (bus.cnt_clr) begin
            cnt1_d = {CW{1'b0}};
            cnt2_d = {CW{1'b0}};
        end else if (gnt1_s) begin
            cnt1_d = sat_inc(cnt1_q);
        end else if (gnt2_s) begin
            cnt2_d = sat_inc(cnt2_q);
        end else begin
            cnt1_d = cnt1_q;
            cnt2_d = cnt2_q;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            ptr_q      <= 1'b1;
            cap_data_q <= {OW{1'b0}};
            cap_src_q  <= 1'b0;
            cnt1_q     <= {CW{1'b0}};
            cnt2_q     <= {CW{1'b0}};
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cap_data_q <= cap_data_d;
            cap_src_q  <= cap_src_d;
            cnt1_q     <= cnt1_d;
            cnt2_q     <= cnt2_d;
        end
    end

    assign bus.req1_ready = gnt1_s;
    assign bus.req2_ready = gnt2_s;
    assign bus.cap_valid  = (state_q == ST_FULL);
    assign bus.cap_data   = cap_data_q;
    assign bus.cap_src    = cap_src_q;
    assign bus.grant_cnt1 = cnt1_q;
    assign bus.grant_cnt2 = cnt2_q;

endmodule

// File: tb/tb_capture_rr_arbiter.sv
// Scoreboard bench for capture_rr_arbiter: a reference model predicts grants and
// captures, a separate monitor checks each capture the DUT presents.
module tb_capture_rr_arbiter;
    localparam int DW   = 3;
    localparam int OW   = 4;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    capture_rr_arbiter_if #(.DW(DW), .OW(OW), .CW(CW)) bus ();

    capture_rr_arbiter #(.DW(DW), .OW(OW), .CW(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    typedef struct {
        int data;
        int src;
        int c1;
        int c2;
    } item_t;

    item_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    bit m_full = 1'b0;
    int m_last = 2;
    int m_c1   = 0;
    int m_c2   = 0;

    bit            v1 = 1'b0, v2 = 1'b0;
    logic [DW-1:0] d1 = '0, d2 = '0;
    bit            acc1 = 1'b0, acc2 = 1'b0;

    bit    mon_prev_valid = 1'b0;
    bit    mon_prev_rdy   = 1'b0;
    item_t held;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: slot occupancy, last winner and counters from the arbitration rules.
    always @(negedge clk) begin : model_p
        int    w;
        item_t it;
        if (!reset_n) begin
            m_full = 1'b0;
            m_last = 2;
            m_c1   = 0;
            m_c2   = 0;
            exp_q.delete();
        end else begin
            chk("cap_valid", 32'(bus.cap_valid), 32'(m_full));
            chk("grant_cnt1", 32'(bus.grant_cnt1), m_c1);
            chk("grant_cnt2", 32'(bus.grant_cnt2), m_c2);
            w = 0;
            if (!m_full || bus.cap_ready) begin
                if (bus.req1_valid && bus.req2_valid) w = (m_last == 1) ? 2 : 1;
                else if (bus.req1_valid)             w = 1;
                else if (bus.req2_valid)             w = 2;
            end
            chk("req1_ready", 32'(bus.req1_ready), 32'(w == 1));
            chk("req2_ready", 32'(bus.req2_ready), 32'(w == 2));
            if (bus.cnt_clr) begin
                m_c1 = 0;
                m_c2 = 0;
            end else if (w == 1) begin
                m_c1 = (m_c1 < CMAX) ? m_c1 + 1 : CMAX;
            end else if (w == 2) begin
                m_c2 = (m_c2 < CMAX) ? m_c2 + 1 : CMAX;
            end
            if (w != 0) begin
                it.data = (w == 1) ? int'(bus.req1_data) : int'(bus.req2_data);
                it.src  = w - 1;
                it.c1   = m_c1;
                it.c2   = m_c2;
                exp_q.push_back(it);
                m_full = 1'b1;
                m_last = w;
            end else if (bus.cap_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // Monitor: a new capture appears after an empty slot or a consumed one.
    always @(negedge clk) begin : monitor_p
        item_t it;
        if (!reset_n) begin
            mon_prev_valid = 1'b0;
            mon_prev_rdy   = 1'b0;
        end else begin
            if (bus.cap_valid && (!mon_prev_valid || mon_prev_rdy)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_capture: got data %0h src %0h expected none at %0t",
                             bus.cap_data, bus.cap_src, $time);
                end else begin
                    it = exp_q.pop_front();
                    chk("cap_data", 32'(bus.cap_data), it.data);
                    chk("cap_src", 32'(bus.cap_src), it.src);
                    chk("cap_cnt1", 32'(bus.grant_cnt1), it.c1);
                    chk("cap_cnt2", 32'(bus.grant_cnt2), it.c2);
                    held = it;
                end
            end else if (bus.cap_valid) begin
                chk("cap_data_hold", 32'(bus.cap_data), held.data);
                chk("cap_src_hold", 32'(bus.cap_src), held.src);
            end
            mon_prev_valid = bus.cap_valid;
            mon_prev_rdy   = bus.cap_ready;
        end
    end

    // One cycle of stimulus; an unaccepted request is held (or dropped with pdrop %).
    task automatic step(input int pv1, input int pv2, input int prdy, input int pclr,
                        input int pdrop, input bit fix,
                        input logic [DW-1:0] f1, input logic [DW-1:0] f2);
        if (v1 && !acc1) begin
            if (int'($urandom_range(99)) < pdrop) v1 = 1'b0;
        end else begin
            v1 = (int'($urandom_range(99)) < pv1);
            d1 = fix ? f1 : DW'($urandom);
        end
        if (v2 && !acc2) begin
            if (int'($urandom_range(99)) < pdrop) v2 = 1'b0;
        end else begin
            v2 = (int'($urandom_range(99)) < pv2);
            d2 = fix ? f2 : DW'($urandom);
        end
        bus.req1_valid = v1;
        bus.req1_data  = d1;
        bus.req2_valid = v2;
        bus.req2_data  = d2;
        bus.cap_ready  = (int'($urandom_range(99)) < prdy);
        bus.cnt_clr    = (int'($urandom_range(99)) < pclr);
        @(negedge clk);
        acc1 = bus.req1_ready;
        acc2 = bus.req2_ready;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset in the middle of a clock phase, checked immediately.
    task automatic mid_reset();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_cap_valid", 32'(bus.cap_valid), 32'd0);
        chk("rst_cap_data", 32'(bus.cap_data), 32'd0);
        chk("rst_cap_src", 32'(bus.cap_src), 32'd0);
        chk("rst_cnt1", 32'(bus.grant_cnt1), 32'd0);
        chk("rst_cnt2", 32'(bus.grant_cnt2), 32'd0);
        v1 = 1'b0;
        v2 = 1'b0;
        acc1 = 1'b0;
        acc2 = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req2_valid = 1'b0;
        bus.cnt_clr    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int pv1, pv2, prdy;
        bus.req1_valid = 1'b0;
        bus.req1_data  = '0;
        bus.req2_valid = 1'b0;
        bus.req2_data  = '0;
        bus.cap_ready  = 1'b0;
        bus.cnt_clr    = 1'b0;
        reset_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cap_valid", 32'(bus.cap_valid), 32'd0);
        chk("reset_cap_data", 32'(bus.cap_data), 32'd0);
        reset_n = 1'b1;

        // single req1 transfer, zero-extended into the slot
        step(100, 0, 100, 0, 0, 1'b1, 3'b101, 3'b000);
        chk("t1_cap_valid", 32'(bus.cap_valid), 32'd1);
        chk("t1_cap_data", 32'(bus.cap_data), 32'd5);
        chk("t1_cap_src", 32'(bus.cap_src), 32'd0);
        chk("t1_cnt1", 32'(bus.grant_cnt1), 32'd1);
        step(0, 0, 100, 0, 0, 1'b1, 3'b000, 3'b000);

        // both valid, slot always consumed: alternating grants
        repeat (8) step(100, 100, 100, 0, 0, 1'b1, 3'd1, 3'd6);

        // slot blocked with both requesters waiting, then released
        repeat (5) step(100, 100, 0, 0, 0, 1'b1, 3'd1, 3'd6);
        repeat (4) step(100, 100, 100, 0, 0, 1'b1, 3'd1, 3'd6);
        repeat (2) step(0, 0, 100, 0, 0, 1'b1, 3'd0, 3'd0);

        // counter saturation on req2
        step(0, 0, 100, 100, 0, 1'b1, 3'd0, 3'd0);
        repeat (20) step(0, 100, 100, 0, 0, 1'b0, 3'd0, 3'd0);
        chk("t4_cnt2_sat", 32'(bus.grant_cnt2), 32'd15);
        chk("t4_cnt1_zero", 32'(bus.grant_cnt1), 32'd0);
        step(0, 0, 100, 0, 0, 1'b1, 3'd0, 3'd0);

        // clear coincident with a req1 grant
        step(100, 0, 100, 0, 0, 1'b1, 3'd2, 3'd0);
        step(100, 0, 100, 100, 0, 1'b1, 3'd3, 3'd0);
        chk("t5_cnt1_clr", 32'(bus.grant_cnt1), 32'd0);
        chk("t5_cap_data", 32'(bus.cap_data), 32'd3);
        chk("t5_cap_valid", 32'(bus.cap_valid), 32'd1);

        // reset while full, then a tie must go to req1
        step(100, 0, 100, 0, 0, 1'b1, 3'd7, 3'd0);
        step(100, 100, 0, 0, 0, 1'b1, 3'd4, 3'd5);
        mid_reset();
        step(100, 100, 100, 0, 0, 1'b1, 3'd4, 3'd5);
        chk("t6_tie_src", 32'(bus.cap_src), 32'd0);
        chk("t6_tie_data", 32'(bus.cap_data), 32'd4);

        // randomized traffic
        pv1 = 50; pv2 = 50; prdy = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                pv1  = int'($urandom_range(100));
                pv2  = int'($urandom_range(100));
                prdy = int'($urandom_range(100));
            end
            if (i == 1500) mid_reset();
            step(pv1, pv2, prdy, 3, 10, 1'b0, 3'd0, 3'd0);
        end

        repeat (4) step(0, 0, 100, 0, 0, 1'b1, 3'd0, 3'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
